// File: rtl/anchor_controller.sv
// rtl/anchor_controller.sv - raster-order anchor sequencer for the edge-detection pipeline
// Walks the anchor across the frame and handshakes loader, datapath chain and output writer.
module anchor_controller #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int STEP_X  = 10,
  parameter int COORD_W = 10,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_start,
  input  logic               i_load_done,
  input  logic               i_hyst_final,
  input  logic               i_write_ack,
  output logic               o_load_req,
  output logic               o_anchor_moving,
  output logic               o_write_req,
  output logic [COORD_W-1:0] o_anchor_x,
  output logic [COORD_W-1:0] o_anchor_y,
  output logic               o_busy,
  output logic               o_image_done,
  output logic               o_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_MOVE    = 3'd2;
  localparam logic [2:0] S_PROCESS = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [CNT_W-1:0]   r_wdog;
  logic [CNT_W-1:0]   w_wdog_inc;
  logic               w_timeout;
  logic [COORD_W-1:0] r_anchor_x;
  logic [COORD_W-1:0] r_anchor_y;
  logic [COORD_W:0]   w_x_stepped;
  logic               w_row_end;
  logic               w_last_row;
  logic               r_error;
  logic               w_accept_start;

  // One extra bit on the stepped column so the row-end compare cannot wrap.
  always_comb begin
    w_x_stepped    = {1'b0, r_anchor_x} + (COORD_W+1)'(STEP_X);
    w_row_end      = (w_x_stepped >= (COORD_W+1)'(IMG_W));
    w_last_row     = (r_anchor_y >= COORD_W'(IMG_H - 1));
    w_wdog_inc     = r_wdog + 1'b1;
    w_timeout      = (w_wdog_inc == CNT_W'(TIMEOUT));
    w_accept_start = (r_state == S_IDLE) && i_start;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_LOAD;
      S_LOAD:    if (i_load_done) w_state_next = S_MOVE;
      S_MOVE:    w_state_next = S_PROCESS;
      S_PROCESS: begin
        // A result arriving on the timeout cycle still wins.
        if (i_hyst_final)   w_state_next = S_WRITE;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_WRITE:   if (i_write_ack) w_state_next = S_ADVANCE;
      S_ADVANCE: w_state_next = (w_row_end && w_last_row) ? S_DONE : S_LOAD;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_wdog <= '0;
    end else if (r_state == S_MOVE) begin
      r_wdog <= '0;
    end else if (r_state == S_PROCESS) begin
      r_wdog <= w_wdog_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_anchor_x <= '0;
      r_anchor_y <= '0;
    end else if (w_accept_start) begin
      r_anchor_x <= '0;
      r_anchor_y <= '0;
    end else if (r_state == S_ADVANCE) begin
      if (!w_row_end) begin
        r_anchor_x <= w_x_stepped[COORD_W-1:0];
      end else if (!w_last_row) begin
        r_anchor_x <= '0;
        r_anchor_y <= r_anchor_y + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_error <= 1'b0;
    end else if (w_accept_start) begin
      r_error <= 1'b0;
    end else if ((r_state == S_PROCESS) && !i_hyst_final && w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign o_load_req      = (r_state == S_LOAD);
  assign o_anchor_moving = (r_state == S_MOVE);
  assign o_write_req     = (r_state == S_WRITE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_image_done    = (r_state == S_DONE);
  assign o_anchor_x      = r_anchor_x;
  assign o_anchor_y      = r_anchor_y;
  assign o_error         = r_error;

endmodule

// File: doc/anchor_controller.md
Name: anchor_controller

Overview:
- Frame-level sequencer for the edge-detection pipeline.
- Walks a processing anchor across the image in raster order: STEP_X pixels per step horizontally, then one row down.
- At each anchor position it:
  - requests the input window load;
  - pulses anchor_moving into the blur/gradient/NMS/hyst_controller chain;
  - waits for hyst_final;
  - hands the 10-pixel hysteresis result to the output writer.
- Sits between the top-level start/status interface, the SRAM window loader, the datapath chain and the output writer.

Parameters:
- IMG_W, 640, image width in pixels; must be a multiple of STEP_X.
- IMG_H, 480, image height in rows.
- STEP_X, 10, horizontal anchor step; equals the hyst_out width.
- COORD_W, 10, width of the anchor_x and anchor_y outputs.
- TIMEOUT, 255, maximum cycles to wait for hyst_final before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- load_done  in  1  window loader has finished the window for the current anchor.
- hyst_final  in  1  hyst_controller result valid for the current anchor.
- write_ack  in  1  output writer has accepted the current result.
- load_req  out  1  level request to the window loader.
- anchor_moving  out  1  one-cycle pulse that starts the datapath chain.
- write_req  out  1  level request to the output writer.
- anchor_x  out  COORD_W  current anchor column.
- anchor_y  out  COORD_W  current anchor row.
- busy  out  1  high whenever the state is not IDLE.
- image_done  out  1  one-cycle pulse after the last anchor has been written.
- error  out  1  sticky hyst_final timeout flag.

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on n_rst.
- Reset values:
  - state = IDLE;
  - all outputs 0;
  - anchor_x = anchor_y = 0;
  - watchdog counter = 0.
- All outputs are registered or decoded directly from the state register. No combinational path from any input to any output.
- FSM states: IDLE, LOAD, MOVE, PROCESS, WRITE, ADVANCE, DONE.
- IDLE:
  - start=1 → go to LOAD; clear error; set anchor_x = anchor_y = 0.
  - start is ignored in every other state.
- LOAD:
  - load_req = 1.
  - Stay until load_done=1 is sampled, then go to MOVE.
  - load_done in the first LOAD cycle counts.
  - load_done in any other state is ignored.
- MOVE:
  - anchor_moving = 1 for exactly one cycle, then go to PROCESS.
  - Clear the watchdog counter.
- PROCESS:
  - Watchdog increments each cycle.
  - hyst_final=1 → go to WRITE. hyst_final outside PROCESS is ignored.
  - If the counter reaches TIMEOUT with no hyst_final → set error=1, go to IDLE, leave the anchor unchanged.
  - If hyst_final=1 arrives in the same cycle the counter reaches TIMEOUT, hyst_final wins: go to WRITE, no error.
- WRITE:
  - write_req = 1.
  - Stay until write_ack=1 is sampled, then go to ADVANCE.
- ADVANCE (one cycle):
  - If anchor_x + STEP_X < IMG_W: anchor_x += STEP_X.
  - Else if anchor_y < IMG_H-1: anchor_x = 0, anchor_y += 1.
  - Else (last anchor): go to DONE with coordinates unchanged.
  - In the first two cases, go to LOAD.
- DONE: image_done = 1 for one cycle, then go to IDLE.
- Minimum cycles per anchor, with zero-latency acknowledges: LOAD 1 + MOVE 1 + PROCESS ≥1 + WRITE 1 + ADVANCE 1 = 5.
- anchor_x and anchor_y are stable from LOAD through WRITE of each anchor.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The frame is lost and the next start begins again at (0,0).
- error stays high until the next accepted start.

Test Plan:
- Reset, then IMG_W=30, IMG_H=2, STEP_X=10; start pulse with immediate load_done, hyst_final and write_ack → exactly 6 anchor_moving pulses at (0,0), (10,0), (20,0), (0,1), (10,1), (20,1); one image_done pulse; busy falls the cycle after image_done.
- Delayed handshakes: load_done 3 cycles late, write_ack 4 cycles late → load_req and write_req are held as levels for exactly those cycles; anchor coordinates are unchanged throughout; exactly one anchor_moving pulse per anchor.
- Timeout with TIMEOUT=8: hyst_final withheld at anchor (10,0) → error=1 after 8 PROCESS cycles, busy=0, anchor remains (10,0); next start clears error and restarts at (0,0).
- hyst_final on the exact cycle the watchdog reaches TIMEOUT → no error; proceeds to WRITE.
- Stray inputs: start during PROCESS, and hyst_final and load_done during WRITE → all ignored; the anchor sequence and pulse count are identical to the first scenario.
- n_rst asserted during WRITE at anchor (20,0) → outputs 0 asynchronously; a fresh start restarts at (0,0) and the frame completes with 6 anchors.
